// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {IDLE, STREAM, FULL} fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer with push, pop and flush; exposes occupancy and head entry.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  // A pop on an empty buffer is dropped so count can never underflow.
  assign pop_ok = pop && (count_q != '0);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = tail_q + PW'(1);
      end
      if (pop_ok) begin
        head_d = head_q + PW'(1);
      end
      case ({push, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[head_q];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch initiator: owns the PC, issues one IFU read per credit, buffers returned words for decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter logic [31:0] PC_STEP   = FETCH_PC_STEP,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] fetch_add,
  input  logic [31:0] inst_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int          CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(BUF_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  fetch_state_t  state_q, state_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  cap_entry;
  logic          pop, issue, push;
  logic [CW:0]   occ_now, occ_credit, occ_next;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;

  // Credits count both buffered entries and the read still in flight, minus this cycle's pop.
  assign occ_now    = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign occ_credit = occ_now - {{CW{1'b0}}, pop};
  assign issue      = !redirect_valid && (occ_credit < DEPTH_V);
  assign push       = inflight_q && !redirect_valid;
  assign cap_entry  = '{pc: inflight_pc_q, inst: inst_code};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    state_d       = state_q;
    occ_next      = '0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = IDLE;
    end else begin
      if (issue) begin
        pc_d          = pc_q + PC_STEP;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      occ_next = occ_credit + {{CW{1'b0}}, inflight_d};
      if (occ_next == DEPTH_V) begin
        state_d = FULL;
      end else if (occ_next == '0) begin
        state_d = IDLE;
      end else begin
        state_d = STREAM;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      state_q       <= IDLE;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      state_q       <= state_d;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (cap_entry),
    .pop        (pop && !redirect_valid),
    .flush      (redirect_valid),
    .count      (count),
    .head       (head)
  );

  assign fetch_add = pc_q;
  assign inst_out  = head.inst;
  assign inst_pc   = head.pc;

  // FULL means every credit is consumed by buffered or in-flight entries.
  a_full_occupancy: assert property (@(posedge clock) disable iff (!reset)
    (state_q == FULL) |-> (occ_now == DEPTH_V));

endmodule
